alu_sequencer: RTL and testbench

Hardwired control unit that sequences the shared-bus datapath through fetch (T0-T2) and execute (T3-T5) for register and immediate ALU instructions. It drives every datapath enable directly: Rin/Rout one-hots, PC/MAR/MDR/IR/Y/Z strobes, ALUop and the sign-extended immediate. It also tracks run/halt status and counts retired instructions.

---
 rtl/alu_sequencer_if.sv | 52 +++++
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Control bundle between the alu_sequencer and the shared-bus datapath.
// The step input exists only when SEQ_STEP_EN is defined.
interface alu_sequencer_if #(
    parameter int CNT_W = 16
);
`ifdef SEQ_STEP_EN
    logic             step;
`endif
    logic             start;
    logic             mem_ready;
    logic [31:0]      IR;
    logic [15:0]      Rin;
    logic [15:0]      Rout;
    logic             PCin;
    logic             PCout;
    logic             MARin;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             Zlowin;
    logic             Zlowout;
    logic             IncPC;
    logic             Read;
    logic             Cout;
    logic [3:0]       ALUop;
    logic [31:0]      Imm;
    logic             running;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
`ifdef SEQ_STEP_EN
        input  step,
`endif
        input  start, mem_ready, IR,
        output Rin, Rout, PCin, PCout, MARin, MDRin, MDRout,
        output IRin, Yin, Zlowin, Zlowout, IncPC, Read, Cout,
        output ALUop, Imm, running, halted, illegal, retired
    );

    modport slave (
`ifdef SEQ_STEP_EN
        output step,
`endif
        output start, mem_ready, IR,
        input  Rin, Rout, PCin, PCout, MARin, MDRin, MDRout,
        input  IRin, Yin, Zlowin, Zlowout, IncPC, Read, Cout,
        input  ALUop, Imm, running, halted, illegal, retired
    );
endinterface

// File: rtl/alu_sequencer.sv
// Hardwired fetch/execute sequencer for register and immediate ALU ops.
// Optional single-step mode enabled by defining SEQ_STEP_EN.
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input logic             clock,
    input logic             clear,
    alu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, HALT
    } state_t;

    state_t state, nxt;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_r, is_i, retire, set_ill;
    logic [3:0] alu_sel;
    state_t     after_ret;

    assign op = bus.IR[31:27];
    assign ra = bus.IR[26:23];
    assign rb = bus.IR[22:19];
    assign rc = bus.IR[18:15];

    assign bus.Imm = {{13{bus.IR[18]}}, bus.IR[18:0]};

    assign is_r = (op >= 5'd3) && (op <= 5'd11);
    assign is_i = (op >= 5'd12) && (op <= 5'd14);

    always_comb begin
        alu_sel = 4'd0;
        unique case (1'b1)
            is_r:         alu_sel = op[3:0];
            op == 5'd12:  alu_sel = 4'd3;
            op == 5'd13:  alu_sel = 4'd5;
            op == 5'd14:  alu_sel = 4'd6;
            default:      alu_sel = 4'd0;
        endcase
    end

`ifdef SEQ_STEP_EN
    assign after_ret = bus.step ? T0 : IDLE;
`else
    assign after_ret = T0;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            bus.retired <= '0;
            bus.illegal <= 1'b0;
        end else begin
            state <= nxt;
            if (retire)
                bus.retired <= bus.retired + CNT_W'(1);
            if (set_ill)
                bus.illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt         = state;
        retire      = 1'b0;
        set_ill     = 1'b0;
        bus.Rin     = '0;
        bus.Rout    = '0;
        bus.PCin    = 1'b0;
        bus.PCout   = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zlowin  = 1'b0;
        bus.Zlowout = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.Cout    = 1'b0;
        bus.ALUop   = '0;
        unique case (state)
            IDLE, HALT: begin
                if (bus.start)
                    nxt = T0;
            end
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
                nxt        = T1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready)
                    nxt = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                nxt        = T3;
            end
            // Decode happens here since IR only settles after the T2 edge
            T3: begin
                if (is_r || is_i) begin
                    bus.Rout = 16'(1) << rb;
                    bus.Yin  = 1'b1;
                    nxt      = T4;
                end else if (op == 5'd27) begin
                    nxt = HALT;
                end else begin
                    retire  = 1'b1;
                    set_ill = (op != 5'd26);
                    nxt     = after_ret;
                end
            end
            T4: begin
                bus.ALUop  = alu_sel;
                bus.Zlowin = 1'b1;
                if (is_r)
                    bus.Rout = 16'(1) << rc;
                else
                    bus.Cout = 1'b1;
                nxt = T5;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                bus.Rin     = 16'(1) << ra;
                retire      = 1'b1;
                nxt         = after_ret;
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.running = (state != IDLE) && (state != HALT);
    assign bus.halted  = (state == HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small shared-bus datapath model
// and a write-back scoreboard.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    alu_sequencer_if #(.CNT_W(16)) sif ();

    alu_sequencer #(.CNT_W(16)) dut (
        .clock (clk),
        .clear (clr),
        .bus   (sif)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:15];
    logic [31:0] regs [0:15];
    logic [31:0] pc, mar, mdr, ir_q, y, z, bus_v;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } wb_t;
    wb_t sb [$];

    logic [47:0] strobes;
    logic [98:0] all_out;

    assign sif.IR = ir_q;

    assign strobes = {sif.Rin, sif.Rout, sif.PCin, sif.PCout,
                      sif.MARin, sif.MDRin, sif.MDRout, sif.IRin,
                      sif.Yin, sif.Zlowin, sif.Zlowout, sif.IncPC,
                      sif.Read, sif.Cout, sif.ALUop};
    assign all_out = {strobes, sif.Imm, sif.running, sif.halted,
                      sif.illegal, sif.retired};

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        bus_v = 32'h0;
        for (int i = 0; i < 16; i++)
            if (sif.Rout[i]) bus_v = regs[i];
        if (sif.PCout)   bus_v = pc;
        if (sif.MDRout)  bus_v = mdr;
        if (sif.Zlowout) bus_v = z;
        if (sif.Cout)    bus_v = sif.Imm;
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            pc   <= 32'h0;
            mar  <= 32'h0;
            mdr  <= 32'h0;
            ir_q <= 32'h0;
            y    <= 32'h0;
            z    <= 32'h0;
            for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
            regs[4] <= 32'd10;
            regs[5] <= 32'h34;
            regs[6] <= 32'h45;
        end else begin
            if (sif.MARin) mar <= bus_v;
            if (sif.PCin)  pc  <= bus_v;
            if (sif.Yin)   y   <= bus_v;
            if (sif.Zlowin)
                z <= sif.IncPC ? bus_v + 32'd1 : alu(sif.ALUop, y, bus_v);
            if (sif.MDRin && sif.Read)
                mdr <= sif.mem_ready ? mem[mar[3:0]] : 32'hDEADBEEF;
            if (sif.IRin) ir_q <= mdr;
            for (int i = 0; i < 16; i++)
                if (sif.Rin[i]) regs[i] <= bus_v;
        end
    end

    always @(negedge clk) begin
        if (!clr && sif.Rin != 16'h0) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", sif.Rin, 16'h0);
            end else begin
                automatic wb_t e = sb.pop_front();
                automatic int k = -1;
                for (int i = 0; i < 16; i++)
                    if (sif.Rin[i]) k = i;
                chk("wb_idx", k, e.idx);
                chk("wb_val", bus_v, e.val);
            end
        end
    end

    initial begin
        sif.start     = 1'b0;
        sif.mem_ready = 1'b1;
`ifdef SEQ_STEP_EN
        sif.step      = 1'b1;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 32'hD8000000;
        mem[0] = 32'h192B0000;
        mem[1] = 32'h61A7FFFB;
        mem[2] = 32'hD0000000;
        mem[3] = 32'hD8000000;
        mem[4] = 32'hF8000000;
        mem[5] = 32'hD8000000;
        mem[6] = 32'h192B0000;

        #12;
        chk("reset_outs", all_out, 99'h0);

        @(negedge clk);
        clr = 1'b0;
        sb.push_back('{2, 32'h79});
        sb.push_back('{3, 32'h5});
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        chk("add_t0", {sif.PCout, sif.MARin, sif.IncPC, sif.Zlowin,
                       sif.running}, 5'h1F);
        @(negedge clk);
        chk("add_t1", {sif.Read, sif.MDRin, sif.Zlowout, sif.PCin}, 4'hF);
        @(negedge clk);
        chk("add_t2", {sif.MDRout, sif.IRin}, 2'h3);
        @(negedge clk);
        chk("add_t3", {sif.Rout, sif.Yin}, {16'h0020, 1'b1});
        @(negedge clk);
        chk("add_t4", {sif.Rout, sif.ALUop, sif.Cout, sif.Zlowin},
            {16'h0040, 4'd3, 1'b0, 1'b1});
        @(negedge clk);
        chk("add_t5", {sif.Rin, sif.Zlowout}, {16'h0004, 1'b1});
        @(negedge clk);
        chk("add_retired", sif.retired, 16'd1);
        chk("add_r2", regs[2], 32'h79);

        sif.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_t1", {sif.Read, sif.MDRin}, 2'h3);
            chk("wait_ir", ir_q, 32'h192B0000);
            if (i == 3) sif.mem_ready = 1'b1;
        end
        @(negedge clk);
        chk("wait_pc", pc, 32'd2);
        chk("addi_t2", sif.IRin, 1'b1);
        @(negedge clk);
        chk("addi_imm", sif.Imm, 32'hFFFFFFFB);
        chk("addi_t3", {sif.Rout, sif.Yin}, {16'h0010, 1'b1});
        @(negedge clk);
        chk("addi_t4", {sif.Rout, sif.Cout, sif.ALUop},
            {16'h0000, 1'b1, 4'd3});
        @(negedge clk);
        chk("addi_t5", sif.Rin, 16'h0008);
        @(negedge clk);
        chk("addi_retired", sif.retired, 16'd2);
        chk("addi_r3", regs[3], 32'd5);

        repeat (3) @(negedge clk);
        chk("nop_t3", {strobes, sif.running}, {48'h0, 1'b1});
        @(negedge clk);
        chk("nop_retired", sif.retired, 16'd3);
        repeat (4) @(negedge clk);
        chk("halt_state", {strobes, sif.running, sif.halted},
            {48'h0, 2'b01});
        @(negedge clk);
        chk("halt_hold", {sif.halted, sif.retired}, {1'b1, 16'd3});

        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        chk("resume_pc", {sif.PCout, bus_v}, {1'b1, 32'd4});
        repeat (3) @(negedge clk);
        chk("ill_t3", strobes, 48'h0);
        @(negedge clk);
        chk("ill_flag", {sif.illegal, sif.retired, sif.PCout},
            {1'b1, 16'd4, 1'b1});
        repeat (4) @(negedge clk);
        chk("ill_sticky", {sif.illegal, sif.halted}, 2'b11);

        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_pre_t4", sif.ALUop, 4'd3);
        #2 clr = 1'b1;
        #1;
        chk("clr_outs", all_out, 99'h0);
        chk("sb_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
